rep3_serial_decoder: RTL and testbench

// - Receive end of the triple-repetition serial link: every payload bit arrives as 3 consecutive samples.
// - Majority-votes each sample triple, using the same 2-of-3 carry logic as the combinational vote cell.
// - Assembles WIDTH decoded bits MSB-first into a word and presents it on a valid/ready output.
// - Counts corrected (non-unanimous) triples per word for link-quality monitoring.

---
 rtl/rep3_serial_decoder.sv | 148 ++++++++++++++
 tb/tb_rep3_serial_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rep3_serial_decoder.sv
// Triple-repetition serial link receiver: majority-votes each sample triple and assembles
// WIDTH-bit words MSB-first onto a valid/ready output. Define PARITY_CHECK_EN for a trailing even-parity triple.
module rep3_serial_decoder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_err_cnt,
    output logic             out_par_err
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {ST_RX, ST_PAR, ST_HOLD} state_t;
`else
    typedef enum logic [1:0] {ST_RX, ST_HOLD} state_t;
`endif

    state_t            state, state_nxt;
    logic [1:0]        samp_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              s0, s1;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  err;

    logic accept, triple_done, last_bit, vote, unanimous;

    assign in_ready    = (state != ST_HOLD);
    assign out_valid   = (state == ST_HOLD);
    assign accept      = in_valid && in_ready;
    // A start-of-frame sample always restarts the word, so it never completes a triple.
    assign triple_done = accept && !in_sof && (samp_cnt == 2'd2);
    assign last_bit    = (bit_cnt == BW'(WIDTH - 1));
    assign vote        = (s0 & s1) | (s0 & in_bit) | (s1 & in_bit);
    assign unanimous   = (s0 == s1) && (s1 == in_bit);

    assign out_data    = shreg;
    assign out_err_cnt = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RX;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaulting every combinational output first keeps paths latch-free.
        state_nxt = state;
        unique case (state)
            ST_RX: begin
                if (triple_done && last_bit) begin
`ifdef PARITY_CHECK_EN
                    state_nxt = ST_PAR;
`else
                    state_nxt = ST_HOLD;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PAR: begin
                if (accept && in_sof) begin
                    state_nxt = ST_RX;
                end else if (triple_done) begin
                    state_nxt = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_RX;
                end
            end
            default: state_nxt = ST_RX;
        endcase
    end

`ifdef PARITY_CHECK_EN
    logic par_err;
    assign out_par_err = par_err;
`else
    assign out_par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state; the shift register is reset too so out_data is 0 after reset.
            samp_cnt <= '0;
            bit_cnt  <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            shreg    <= '0;
            err      <= '0;
`ifdef PARITY_CHECK_EN
            par_err  <= 1'b0;
`endif
        end else if (accept) begin
            if (in_sof) begin
                s0       <= in_bit;
                samp_cnt <= 2'd1;
                bit_cnt  <= '0;
                err      <= '0;
            end else begin
                unique case (samp_cnt)
                    2'd0: begin
                        s0       <= in_bit;
                        samp_cnt <= 2'd1;
                    end
                    2'd1: begin
                        s1       <= in_bit;
                        samp_cnt <= 2'd2;
                    end
                    default: begin
                        samp_cnt <= 2'd0;
                        if (!unanimous && !(&err)) begin
                            err <= err + 1'b1;
                        end
                        if (state == ST_RX) begin
                            shreg   <= {shreg[WIDTH-2:0], vote};
                            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                        end
`ifdef PARITY_CHECK_EN
                        else begin
                            par_err <= (^shreg) != vote;
                        end
`endif
                    end
                endcase
            end
        end else if (out_valid && out_ready) begin
            err     <= '0;
`ifdef PARITY_CHECK_EN
            par_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_rep3_serial_decoder.sv
// Self-checking bench for rep3_serial_decoder: directed cases plus randomized words
// checked against a sample-counting reference model; honours PARITY_CHECK_EN.
module tb_rep3_serial_decoder;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_sof, in_bit, out_ready;
    logic sel16;

    logic        rdy8, val8, par8;
    logic [7:0]  data8;
    logic [3:0]  err8;
    logic        rdy16, val16, par16;
    logic [15:0] data16;
    logic [3:0]  err16;

    logic        cur_ready, cur_valid, cur_par;
    logic [15:0] cur_data;
    logic [3:0]  cur_err;

    int checks   = 0;
    int failures = 0;
    bit gaps     = 1'b0;
    bit smp[$];

    always #5 clk = ~clk;

    rep3_serial_decoder #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel16), .in_sof(in_sof), .in_bit(in_bit),
        .in_ready(rdy8), .out_valid(val8), .out_ready(out_ready && !sel16),
        .out_data(data8), .out_err_cnt(err8), .out_par_err(par8)
    );

    rep3_serial_decoder #(.WIDTH(16), .CNT_W(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel16), .in_sof(in_sof), .in_bit(in_bit),
        .in_ready(rdy16), .out_valid(val16), .out_ready(out_ready && sel16),
        .out_data(data16), .out_err_cnt(err16), .out_par_err(par16)
    );

    always_comb begin
        cur_ready = sel16 ? rdy16 : rdy8;
        cur_valid = sel16 ? val16 : val8;
        cur_par   = sel16 ? par16 : par8;
        cur_data  = sel16 ? data16 : {8'h00, data8};
        cur_err   = sel16 ? err16 : err8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the sample stream for one word. mode: 0 clean, 1 invert s1 of every triple,
    // 2 flip exactly one random sample per triple, 3 flip one sample half the time, 4 fully random.
    task automatic build(input logic [15:0] w, input int nb, input int mode, input logic [2:0] par_trip);
        logic [2:0] t;
        logic       b;
        smp.delete();
        for (int i = 0; i < nb; i++) begin
            b = w[nb-1-i];
            t = {b, b, b};
            case (mode)
                1: t[1] = ~b;
                2: t[$urandom_range(0, 2)] = ~b;
                3: if ($urandom_range(0, 1) == 1) t[$urandom_range(0, 2)] = ~b;
                4: t = 3'($urandom_range(0, 7));
                default: ;
            endcase
            smp.push_back(t[0]);
            smp.push_back(t[1]);
            smp.push_back(t[2]);
        end
`ifdef PARITY_CHECK_EN
        smp.push_back(par_trip[0]);
        smp.push_back(par_trip[1]);
        smp.push_back(par_trip[2]);
`endif
    endtask

    // Reference: each triple votes by counting ones; disagreements are counted and capped.
    task automatic model(input int nb, output logic [15:0] d, output int e, output logic p);
        int ones;
        d = '0;
        e = 0;
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            ones = int'(smp[3*i]) + int'(smp[3*i+1]) + int'(smp[3*i+2]);
            d = (d << 1) | 16'(ones >= 2);
            if (ones == 1 || ones == 2) e++;
        end
`ifdef PARITY_CHECK_EN
        ones = int'(smp[3*nb]) + int'(smp[3*nb+1]) + int'(smp[3*nb+2]);
        if (ones == 1 || ones == 2) e++;
        p = (^d) != (ones >= 2);
`endif
        if (e > 15) e = 15;
    endtask

    task automatic push(input logic b, input logic sof);
        int n;
        n = 0;
        @(negedge clk);
        if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        in_sof   = sof;
        while (!cur_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drive(input logic first_sof);
        for (int i = 0; i < smp.size(); i++) begin
            if (i == smp.size() - 1) check("pre_last_valid", 32'(cur_valid), 32'd0);
            push(smp[i], (i == 0) && first_sof);
        end
    endtask

    task automatic expect_word(input string tag, input logic [15:0] d, input int e, input logic p, input int hold);
        check({tag, "_valid"}, 32'(cur_valid), 32'd1);
        check({tag, "_data"}, 32'(cur_data), 32'(d));
        check({tag, "_err"}, 32'(cur_err), 32'(e));
        check({tag, "_par"}, 32'(cur_par), 32'(p));
        check({tag, "_inrdy_hold"}, 32'(cur_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(cur_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(cur_data), 32'(d));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(cur_valid), 32'd0);
        check({tag, "_rel_inrdy"}, 32'(cur_ready), 32'd1);
    endtask

    task automatic run_word(input string tag, input logic [15:0] w, input int nb, input int mode,
                            input logic [2:0] par_trip, input logic sof, input int hold);
        logic [15:0] d;
        int          e;
        logic        p;
        build(w, nb, mode, par_trip);
        model(nb, d, e, p);
        drive(sof);
        expect_word(tag, d, e, p, hold);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(cur_valid), 32'd0);
        check({tag, "_data"}, 32'(cur_data), 32'd0);
        check({tag, "_err"}, 32'(cur_err), 32'd0);
        check({tag, "_par"}, 32'(cur_par), 32'd0);
    endtask

    task automatic pulse_reset_and_watch(input string tag);
        bit seen;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(tag);
        check({tag, "_inrdy"}, 32'(cur_ready), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cur_valid) seen = 1'b1;
        end
        check({tag, "_no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        sel16     = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_inrdy", 32'(cur_ready), 32'd1);

        run_word("clean_a5", 16'h00A5, 8, 0, 3'b000, 1'b1, 0);
        run_word("s1_inv_3c", 16'h003C, 8, 1, 3'b000, 1'b1, 5);

        // Partial word of 10 samples, then restart with in_sof.
        for (int i = 0; i < 10; i++) push(1'($urandom_range(0, 1)), i == 0);
        run_word("sof_ff", 16'h00FF, 8, 0, 3'b000, 1'b1, 1);

`ifdef PARITY_CHECK_EN
        run_word("par_01_000", 16'h0001, 8, 0, 3'b000, 1'b1, 0);
        run_word("par_01_111", 16'h0001, 8, 0, 3'b111, 1'b1, 0);
`endif

        gaps = 1'b1;
        for (int n = 0; n < 24; n++) begin
            run_word("rand", 16'($urandom_range(0, 255)), 8, int'($urandom_range(0, 4)),
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
        gaps = 1'b0;

        sel16 = 1'b1;
        run_word("w16_sat", 16'($urandom), 16, 2, 3'b010, 1'b1, 2);
        run_word("w16_rand", 16'($urandom), 16, 3, 3'($urandom_range(0, 7)), 1'b1, 0);
        sel16 = 1'b0;

        // Reset at sample 12 of a word: the word is lost.
        build(16'h005A, 8, 0, 3'b000);
        for (int i = 0; i < 12; i++) push(smp[i], i == 0);
        pulse_reset_and_watch("rst_mid_word");
        run_word("after_rst_word", 16'h00C3, 8, 3, 3'b111, 1'b1, 0);

        // Reset while holding a finished word.
        build(16'h0096, 8, 0, 3'b000);
        drive(1'b1);
        check("hold_before_rst", 32'(cur_valid), 32'd1);
        pulse_reset_and_watch("rst_mid_hold");
        run_word("after_rst_hold", 16'h0069, 8, 0, 3'b000, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
